fir_out_i2s_tx: RTL

- Downstream stage of the parallel FIR. Consumes the FIR's signed y_out and its single-cycle valid strobe.
- Rounds and saturates each result to the DAC word width, buffers it in a small FIFO, and serialises it as a standard I2S stream.
- The same sample is sent on both left and right channels.
- Exposes overflow, underflow and saturation status for register readout.

---
 rtl/fir_out_i2s_tx.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/fir_out_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_i2s_tx
// Brief    : FIR output conditioner and I2S transmitter. Rounds/saturates the
//            signed FIR result to the DAC word width, queues it in a small
//            FIFO and serialises it on both I2S channels (one-BCLK delay,
//            MSB first). Reports overflow, underflow and clipping status.
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_i2s_tx #(
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_DIV   = 4,
    parameter int SLOT_BITS  = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          valid_strobe_in,
    input  logic signed [IN_WIDTH-1:0]    y_in,
    output logic                          bclk_o,
    output logic                          lrclk_o,
    output logic                          sdata_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          sat_o,
    output logic [7:0]                    overflow_cnt_o,
    output logic [7:0]                    underflow_cnt_o
);

    // Working width wide enough for rounding carry and left alignment
    localparam int c_RW = IN_WIDTH + OUT_WIDTH + 1;
    localparam int c_D  = IN_WIDTH - SHIFT - OUT_WIDTH;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_DW = $clog2(BCLK_DIV);
    localparam int c_BW = $clog2(2 * SLOT_BITS);

    localparam logic signed [c_RW-1:0] c_MAX = c_RW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [c_RW-1:0] c_MIN = ~c_MAX;

    // ------------------------------------------------------------------
    // Conditioning: gain trim, round half up, clamp
    // ------------------------------------------------------------------
    logic signed [c_RW-1:0]  w_y_ext;
    logic signed [c_RW-1:0]  w_p;
    logic signed [c_RW-1:0]  w_r;
    logic [OUT_WIDTH-1:0]    w_word;
    logic                    w_clip;

    assign w_y_ext = {{(c_RW - IN_WIDTH){y_in[IN_WIDTH-1]}}, y_in};
    assign w_p     = w_y_ext >>> SHIFT;

    generate
        if (c_D > 0) begin : g_round
            localparam logic signed [c_RW-1:0] c_HALF = c_RW'(1) << (c_D - 1);
            assign w_r = (w_p + c_HALF) >>> c_D;
        end else begin : g_widen
            assign w_r = w_p <<< (-c_D);
        end
    endgenerate

    // Clamp the rounded value into the signed output range
    always_comb begin
        w_clip = 1'b0;
        w_word = w_r[OUT_WIDTH-1:0];
        if (w_r > c_MAX) begin
            w_clip = 1'b1;
            w_word = c_MAX[OUT_WIDTH-1:0];
        end else if (w_r < c_MIN) begin
            w_clip = 1'b1;
            w_word = c_MIN[OUT_WIDTH-1:0];
        end
    end

    logic                 r_s1_valid;
    logic [OUT_WIDTH-1:0] r_s1_word;
    logic                 r_sat;

    // Stage-1 register; strobes are ignored while disabled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_word  <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_s1_valid <= valid_strobe_in && enable_i;
            r_sat      <= valid_strobe_in && enable_i && w_clip;
            if (valid_strobe_in && enable_i) begin
                r_s1_word <= w_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // BCLK divider and serializer timing
    // ------------------------------------------------------------------
    logic [c_DW-1:0]      r_div;
    logic                 r_bclk;
    logic [c_BW-1:0]      r_bit;
    logic                 r_lrclk;
    logic                 r_sdata;
    logic [OUT_WIDTH-1:0] r_word;

    logic                 w_div_end;
    logic                 w_fall;
    logic                 w_wrap;
    logic [c_BW-1:0]      w_bit_nxt;
    logic [c_BW-1:0]      w_slot;
    logic [OUT_WIDTH-1:0] w_sh;
    logic                 w_sdata_nxt;

    assign w_div_end = (r_div == c_DW'(BCLK_DIV - 1));
    assign w_fall    = w_div_end && r_bclk;
    assign w_wrap    = w_fall && (r_bit == c_BW'(2 * SLOT_BITS - 1));
    assign w_bit_nxt = (r_bit == c_BW'(2 * SLOT_BITS - 1)) ? '0 : r_bit + c_BW'(1);
    assign w_slot    = (w_bit_nxt >= c_BW'(SLOT_BITS)) ? w_bit_nxt - c_BW'(SLOT_BITS)
                                                        : w_bit_nxt;
    // Slot position s selects word[OUT_WIDTH-s]: shift it up to the MSB
    assign w_sh        = r_word << (w_slot - c_BW'(1));
    assign w_sdata_nxt = (w_slot != '0) && (w_slot <= c_BW'(OUT_WIDTH)) && w_sh[OUT_WIDTH-1];

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr;
    logic [c_AW-1:0]      r_rd;
    logic [c_LW-1:0]      r_level;
    logic [7:0]           r_ovf;
    logic [7:0]           r_uf;

    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_uf;

    assign w_pop  = enable_i && w_wrap && (r_level != '0);
    assign w_uf   = enable_i && w_wrap && (r_level == '0);
    // A full FIFO still accepts a write in the cycle it is popped
    assign w_push = enable_i && r_s1_valid && ((r_level != c_LW'(FIFO_DEPTH)) || w_pop);
    assign w_drop = enable_i && r_s1_valid && !w_push;

    // Bit clock, bit index and serial outputs; all cleared while disabled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div   <= '0;
            r_bclk  <= 1'b0;
            r_bit   <= '0;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
            r_word  <= '0;
        end else if (!enable_i) begin
            r_div   <= '0;
            r_bclk  <= 1'b0;
            r_bit   <= '0;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
            r_word  <= '0;
        end else begin
            if (w_div_end) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div <= r_div + c_DW'(1);
            end
            if (w_fall) begin
                r_bit   <= w_bit_nxt;
                r_lrclk <= (w_bit_nxt >= c_BW'(SLOT_BITS));
                r_sdata <= w_sdata_nxt;
                if (w_wrap) begin
                    r_word <= w_pop ? r_mem[r_rd] : '0;
                end
            end
        end
    end

    // Sample storage (data only, no reset needed)
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr] <= r_s1_word;
        end
    end

    // FIFO pointers and occupancy; flushed while disabled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (!enable_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Saturating status counters; they hold their value while disabled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= '0;
            r_uf  <= '0;
        end else begin
            if (w_drop && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 8'd1;
            end
            if (w_uf && (r_uf != 8'hFF)) begin
                r_uf <= r_uf + 8'd1;
            end
        end
    end

    assign bclk_o          = r_bclk;
    assign lrclk_o         = r_lrclk;
    assign sdata_o         = r_sdata;
    assign fifo_level_o    = r_level;
    assign sat_o           = r_sat;
    assign overflow_cnt_o  = r_ovf;
    assign underflow_cnt_o = r_uf;

endmodule
`default_nettype wire
